// File: rtl/ppi_bus_pkg.sv
// ==========================================================================
// ppi_bus_pkg: shared FSM state codes and PPI register selects.  Rev 1.0
// ==========================================================================
`default_nettype none

package ppi_bus_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_RST    = 3'd0;
   localparam state_t ST_IDLE   = 3'd1;
   localparam state_t ST_SETUP  = 3'd2;
   localparam state_t ST_STROBE = 3'd3;
   localparam state_t ST_HOLD   = 3'd4;

   localparam logic [1:0] PORT_A    = 2'b00;
   localparam logic [1:0] PORT_B    = 2'b01;
   localparam logic [1:0] PORT_C    = 2'b10;
   localparam logic [1:0] PORT_CTRL = 2'b11;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ppi_phase_timer.sv
// ==========================================================================
// ppi_phase_timer: loadable down-counter, done while the count is zero.  Rev 1.0
// ==========================================================================
`default_nettype none

module ppi_phase_timer #(
   parameter int               WIDTH = 3,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             done
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= INIT;
      end else if (load) begin
         r_count <= load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign done = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/ppi_bus_master.sv
// ==========================================================================
// ppi_bus_master: host valid/ready requests to timed 8255 PPI bus cycles.  Rev 1.0
// ==========================================================================
`default_nettype none

module ppi_bus_master
   import ppi_bus_pkg::*;
#(
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1,
   parameter int RST_CYC   = 4
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic [1:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       PPI_RESET,
   output logic [1:0] A,
   output logic       CS,
   output logic       READ,
   output logic       WRITE,
   inout  wire  [7:0] DATA
);

   localparam int CNT_W = $clog2(max4(SETUP_CYC, PULSE_CYC, HOLD_CYC, RST_CYC) + 1);

   // Timer counts down to zero, so each phase loads its length minus one.
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] RST_LD   = CNT_W'(RST_CYC - 1);

   state_t           r_state;
   logic             r_write;
   logic [1:0]       r_addr;
   logic [7:0]       r_wdata;
   logic             r_drive;
   logic             r_cs;
   logic             r_rd;
   logic             r_wr;
   logic             r_ppi_rst;
   logic             r_rsp_valid;
   logic [7:0]       r_rdata;

   logic             w_load;
   logic [CNT_W-1:0] w_load_val;
   logic             w_done;

   ppi_phase_timer #(
      .WIDTH (CNT_W),
      .INIT  (RST_LD)
   ) u_timer (
      .clk      (CLK),
      .rst_n    (RESET_N),
      .load     (w_load),
      .load_val (w_load_val),
      .done     (w_done)
   );

   always_comb begin
      w_load     = 1'b0;
      w_load_val = '0;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_load     = 1'b1;
               w_load_val = SETUP_LD;
            end
         end
         ST_SETUP: begin
            if (w_done) begin
               w_load     = 1'b1;
               w_load_val = PULSE_LD;
            end
         end
         ST_STROBE: begin
            if (w_done) begin
               w_load     = 1'b1;
               w_load_val = HOLD_LD;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state     <= ST_RST;
         r_write     <= 1'b0;
         r_addr      <= PORT_A;
         r_wdata     <= 8'h00;
         r_drive     <= 1'b0;
         r_cs        <= 1'b1;
         r_rd        <= 1'b1;
         r_wr        <= 1'b1;
         r_ppi_rst   <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rdata     <= 8'h00;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            ST_RST: begin
               // One extra cycle after PPI_RESET drops before the host is served.
               if (w_done) begin
                  if (r_ppi_rst) r_ppi_rst <= 1'b0;
                  else           r_state   <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (req_valid) begin
                  r_write <= req_write;
                  r_addr  <= req_addr;
                  r_wdata <= req_wdata;
                  r_drive <= req_write;
                  r_cs    <= 1'b0;
                  r_state <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (w_done) begin
                  if (r_write) r_wr <= 1'b0;
                  else         r_rd <= 1'b0;
                  r_state <= ST_STROBE;
               end
            end
            ST_STROBE: begin
               if (w_done) begin
                  r_rd    <= 1'b1;
                  r_wr    <= 1'b1;
                  r_rdata <= r_write ? 8'h00 : DATA;
                  r_state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (w_done) begin
                  r_cs        <= 1'b1;
                  r_drive     <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_cs      <= 1'b1;
               r_rd      <= 1'b1;
               r_wr      <= 1'b1;
               r_drive   <= 1'b0;
               r_ppi_rst <= 1'b1;
               r_state   <= ST_RST;
            end
         endcase
      end
   end

   assign req_ready = (r_state == ST_IDLE);
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rdata;
   assign PPI_RESET = r_ppi_rst;
   assign A         = r_addr;
   assign CS        = r_cs;
   assign READ      = r_rd;
   assign WRITE     = r_wr;
   assign DATA      = r_drive ? r_wdata : 8'hzz;

endmodule

`default_nettype wire

// File: doc/ppi_bus_master.md
# ppi_bus_master

Bus-initiator for the 8255-style PPI: turns single-beat read/write requests from a host-side valid/ready port into correctly timed active-low CS/READ/WRITE cycles on the PPI's A/DATA bus. It drives the PPI reset after system reset and captures read data. It sits between the host logic and the PPI top module, the CPU-side counterpart of the PPI's bus interface.

## Interface
- SETUP_CYC, 1: cycles CS low with A/DATA stable before the strobe (≥1)
- PULSE_CYC, 2: cycles READ/WRITE held low (≥1)
- HOLD_CYC, 1: cycles CS low after strobe release, A/DATA still held (≥1)
- RST_CYC, 4: cycles PPI_RESET stays high after RESET_N release (≥1)
- CLK  in  1  single clock, all state on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- req_valid  in  1  host request present
- req_ready  out  1  high only in IDLE with PPI reset finished
- req_write  in  1  1 = write, 0 = read
- req_addr  in  2  PPI register select (00 A, 01 B, 10 C, 11 control)
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle completion pulse (reads and writes)
- rsp_rdata  out  8  captured read data; 0x00 for writes
- PPI_RESET  out  1  active-high reset to PPI
- A  out  2  PPI address
- CS, READ, WRITE  out  1 each  active-low PPI strobes
- DATA  inout  8  PPI data bus; driven only during write cycles, else Z

## Operation
- Reset (RESET_N low, async): CS=READ=WRITE=1, A=00, DATA=Z, PPI_RESET=1, req_ready=0, rsp_valid=0, rsp_rdata=0x00, FSM=RST.
- RST: PPI_RESET held RST_CYC cycles after RESET_N rises, then 0; go IDLE.
- IDLE: req_ready=1. On req_valid&req_ready, latch write/addr/wdata; go SETUP.
- SETUP (SETUP_CYC cycles): A=latched addr, CS=0, DATA=wdata if write else Z.
- STROBE (PULSE_CYC cycles): WRITE=0 (write) or READ=0 (read). Read: DATA sampled into rsp_rdata at the final STROBE clock edge.
- HOLD (HOLD_CYC cycles): strobes high, CS=0, A/DATA held.
- Exit HOLD to IDLE: CS=1, DATA=Z, rsp_valid=1 for exactly that cycle.
- Request inputs ignored outside IDLE; host must hold until accepted.
- Single phase down-counter reloaded on each state entry; width $clog2(max param + 1).

## Timing
- Accept edge T. SETUP T+1..T+S; STROBE T+S+1..T+S+P; HOLD next H cycles; IDLE with rsp_valid at T+S+P+H+1 (defaults: T+5).
- req_ready high in the rsp_valid cycle; back-to-back requests give exactly one cycle CS=1 between transactions (bus turnaround, no DATA contention).
- All bus outputs registered; no combinational path from req_* to A/CS/READ/WRITE/DATA.
- RESET_N low mid-transaction: bus released immediately, no rsp_valid, re-run RST sequence.
- READ and WRITE never low simultaneously; neither low while CS=1.

## Structure
- Package ppi_bus_pkg: FSM state enum (RST, IDLE, SETUP, STROBE, HOLD), register-select constants PORT_A/B/C/CTRL.
- One sub-module: ppi_phase_timer (loadable down-counter, done flag), shared by all timed states.

## Test plan
- Reset: RESET_N low 3 cycles -> all reset values above; PPI_RESET falls exactly 4 cycles after release; req_ready rises next cycle.
- Write control 0x9B to 11 -> CS low 4 cycles, WRITE low cycles 2-3, DATA=0x9B throughout CS low, A=11, rsp_valid at T+5, rsp_rdata=0x00.
- Read port A, model drives 0x0A when READ low -> READ low 2 cycles, DATA never driven by master, rsp_rdata=0x0A with rsp_valid at T+5.
- Back-to-back read B (0x14) then write C (0x1E), req_valid held -> one CS-high cycle between, responses 0x14 then 0x00.
- RESET_N low during STROBE -> CS/WRITE high and DATA=Z same cycle, no rsp_valid, full PPI_RESET sequence repeats.
- Parameters 3/1/2 -> CS low 6 cycles, strobe low 1 cycle, rsp_valid at T+7.
